// File: rtl/mips_pkg.sv
// mips_pkg: control-word bit positions and MEM-stage FSM states shared across the pipeline
package mips_pkg;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/data_ram.sv
// data_ram: word-addressed data memory with synchronous write and asynchronous read
module data_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with multi-cycle data RAM access and the MEM/WB pipeline register
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  rd_in,
  input  logic [3:0]  control_in,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_rd_out,
  output logic        wb_reg_write_out,
  output logic        mem_err_out
);
  localparam int CW = MEM_LATENCY > 0 ? $clog2(MEM_LATENCY + 1) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic mem_op, illegal, legal_mem, complete, we;
  logic [31:0] rdata;
  logic unused_hi;
  assign unused_hi = ^alu_result_in[31:ADDR_W+2];
  always_comb begin
    mem_op    = control_in[CTRL_MEMREAD] | control_in[CTRL_MEMWRITE];
    illegal   = (control_in[CTRL_MEMREAD] & control_in[CTRL_MEMWRITE]) | (mem_op & (alu_result_in[1:0] != 2'b00));
    legal_mem = mem_op & ~illegal;
    complete  = legal_mem & (state == WAIT || MEM_LATENCY == 0) & (cnt == CW'(MEM_LATENCY));
    stall_out = legal_mem & ~complete;
    state_nxt = stall_out ? WAIT : IDLE;
    cnt_nxt   = stall_out ? cnt + CW'(1) : '0;
    we        = complete & control_in[CTRL_MEMWRITE] & ~rst;
  end
  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (alu_result_in[ADDR_W+1:2]),
    .wdata(rd2_in),
    .rdata(rdata)
  );
  // bubbles clear only the enables; data/rd hold their last retired values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      wb_data_out      <= '0;
      wb_rd_out        <= '0;
      wb_reg_write_out <= 1'b0;
      mem_err_out      <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      wb_reg_write_out <= ~stall_out & ~illegal & control_in[CTRL_REGWRITE];
      mem_err_out      <= illegal;
      if (!stall_out) begin
        wb_data_out <= (complete & control_in[CTRL_MEMREAD] & control_in[CTRL_MEMTOREG]) ? rdata : alu_result_in;
        wb_rd_out   <= rd_in;
      end
    end
  end
endmodule
